uart_rx: RTL

- 8N1 UART receiver, the receive end of the team's UART link.
- Samples an asynchronous serial line and reassembles the 8-bit payload LSB-first.
- Presents each good byte with a one-cycle valid strobe.
- Flags framing errors and filters start-bit glitches.
- Sits between an external rx pin and the consumer logic, in the same clock domain as the transmitter.

---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   Samples an asynchronous serial line through a 2-flop synchronizer.
//   Rebuilds the 8-bit payload LSB-first using mid-bit sampling.
//   Each good byte is presented with a one-cycle valid strobe.
//   A stop bit sampled low raises a one-cycle framing_error pulse.
//   After a framing error the receiver waits for the line to return high.
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   rx             in   serial line, idle high, asynchronous to clock
//   data[7:0]      out  last correctly received byte
//   valid          out  one-cycle pulse, data updated in the same cycle
//   framing_error  out  one-cycle pulse when the stop bit samples 0
//   busy           out  high while a frame is in progress
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CYC_ZERO = '0;
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            fe_q, fe_d;
  logic            busy_q, busy_d;

  // Synchronizer, FSM state, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cyc_q     <= CYC_ZERO;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and output decode; decisions use only the synchronized line.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    // busy lags the state by one cycle so it covers the strobe cycle.
    busy_d  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cyc_d   = CYC_ZERO;
        end else begin
          cyc_d   = CYC_ZERO;
        end
      end
      S_START: begin
        // Re-check the line at mid start bit; a high line is a glitch.
        if (cyc_q == CYC_HALF) begin
          cyc_d = CYC_ZERO;
          if (!rx_s_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      S_DATA: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = CYC_ZERO;
          // Shift right so the first bit received lands in bit 0.
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      S_STOP: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = CYC_ZERO;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      S_BREAK: begin
        // A held-low line must not be mistaken for a stream of new frames.
        cyc_d = CYC_ZERO;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = CYC_ZERO;
        bit_d   = 3'd0;
      end
    endcase
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign busy          = busy_q;

endmodule
